// File: rtl/ps2_key_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ps2_key_decoder                                               |
// | Purpose  : Pops key events from the PS/2 receiver FIFO, tracks the       |
// |            shift/ctrl/caps modifier state and translates set-2 make      |
// |            codes into 7-bit ASCII held in a single-entry valid/ready     |
// |            output register.                                              |
// | Ports    : clk, clr            - clock, synchronous active-high reset    |
// |            kb_ready/kb_keyup/kb_extend/kb_scancode - receiver FIFO head  |
// |            kb_overflow         - receiver sticky overflow flag           |
// |            kb_nextdata_n       - active-low pop strobe to the receiver   |
// |            ascii/ascii_valid/ascii_ready - character output handshake    |
// |            mods                - {caps, ctrl, shift}                     |
// |            overflow            - registered copy of kb_overflow          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module ps2_key_decoder #(
    parameter logic CAPS_INIT = 1'b0,
    parameter logic CTRL_MAP  = 1'b1
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       kb_ready,
    input  logic       kb_keyup,
    input  logic       kb_extend,
    input  logic [7:0] kb_scancode,
    input  logic       kb_overflow,
    output logic       kb_nextdata_n,
    output logic [7:0] ascii,
    output logic       ascii_valid,
    input  logic       ascii_ready,
    output logic [2:0] mods,
    output logic       overflow
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_LOOKUP = 2'd1;
    localparam logic [1:0] c_ST_EMIT   = 2'd2;

    logic [1:0] r_state;
    logic       r_keyup;
    logic       r_extend;
    logic [7:0] r_code;
    logic       r_shift;
    logic       r_ctrl;
    logic       r_caps;
    logic [6:0] r_ascii;
    logic       r_valid;
    logic       r_overflow;

    logic       w_pop;
    logic [6:0] w_lo;
    logic [6:0] w_hi;
    logic       w_letter;
    logic       w_hit;
    logic       w_is_shift;
    logic       w_is_ctrl;
    logic       w_is_caps;
    logic       w_keep;
    logic [6:0] w_char;

    // The pop is combinational so the head fields sampled at this edge are
    // exactly the event being released; clr suppresses it outright.
    assign w_pop         = ~clr & (r_state == c_ST_IDLE) & kb_ready & ~r_valid;
    assign kb_nextdata_n = ~w_pop;

    // Unshifted / shifted glyph per make code. A zero unshifted glyph means
    // the code has no table entry.
    always_comb begin
        w_lo     = 7'h00;
        w_hi     = 7'h00;
        w_letter = 1'b0;
        case (r_code)
            8'h1C: begin w_letter = 1'b1; w_lo = 7'h61; end // a
            8'h32: begin w_letter = 1'b1; w_lo = 7'h62; end
            8'h21: begin w_letter = 1'b1; w_lo = 7'h63; end
            8'h23: begin w_letter = 1'b1; w_lo = 7'h64; end
            8'h24: begin w_letter = 1'b1; w_lo = 7'h65; end
            8'h2B: begin w_letter = 1'b1; w_lo = 7'h66; end
            8'h34: begin w_letter = 1'b1; w_lo = 7'h67; end
            8'h33: begin w_letter = 1'b1; w_lo = 7'h68; end
            8'h43: begin w_letter = 1'b1; w_lo = 7'h69; end
            8'h3B: begin w_letter = 1'b1; w_lo = 7'h6A; end
            8'h42: begin w_letter = 1'b1; w_lo = 7'h6B; end
            8'h4B: begin w_letter = 1'b1; w_lo = 7'h6C; end
            8'h3A: begin w_letter = 1'b1; w_lo = 7'h6D; end
            8'h31: begin w_letter = 1'b1; w_lo = 7'h6E; end
            8'h44: begin w_letter = 1'b1; w_lo = 7'h6F; end
            8'h4D: begin w_letter = 1'b1; w_lo = 7'h70; end
            8'h15: begin w_letter = 1'b1; w_lo = 7'h71; end
            8'h2D: begin w_letter = 1'b1; w_lo = 7'h72; end
            8'h1B: begin w_letter = 1'b1; w_lo = 7'h73; end
            8'h2C: begin w_letter = 1'b1; w_lo = 7'h74; end
            8'h3C: begin w_letter = 1'b1; w_lo = 7'h75; end
            8'h2A: begin w_letter = 1'b1; w_lo = 7'h76; end
            8'h1D: begin w_letter = 1'b1; w_lo = 7'h77; end
            8'h22: begin w_letter = 1'b1; w_lo = 7'h78; end
            8'h35: begin w_letter = 1'b1; w_lo = 7'h79; end
            8'h1A: begin w_letter = 1'b1; w_lo = 7'h7A; end // z
            8'h45: begin w_lo = 7'h30; w_hi = 7'h29; end     // 0 )
            8'h16: begin w_lo = 7'h31; w_hi = 7'h21; end     // 1 !
            8'h1E: begin w_lo = 7'h32; w_hi = 7'h40; end     // 2 @
            8'h26: begin w_lo = 7'h33; w_hi = 7'h23; end     // 3 #
            8'h25: begin w_lo = 7'h34; w_hi = 7'h24; end     // 4 $
            8'h2E: begin w_lo = 7'h35; w_hi = 7'h25; end     // 5 %
            8'h36: begin w_lo = 7'h36; w_hi = 7'h5E; end     // 6 ^
            8'h3D: begin w_lo = 7'h37; w_hi = 7'h26; end     // 7 &
            8'h3E: begin w_lo = 7'h38; w_hi = 7'h2A; end     // 8 *
            8'h46: begin w_lo = 7'h39; w_hi = 7'h28; end     // 9 (
            8'h4E: begin w_lo = 7'h2D; w_hi = 7'h5F; end     // - _
            8'h55: begin w_lo = 7'h3D; w_hi = 7'h2B; end     // = +
            8'h54: begin w_lo = 7'h5B; w_hi = 7'h7B; end     // [ {
            8'h5B: begin w_lo = 7'h5D; w_hi = 7'h7D; end     // ] }
            8'h5D: begin w_lo = 7'h5C; w_hi = 7'h7C; end     // backslash |
            8'h4C: begin w_lo = 7'h3B; w_hi = 7'h3A; end     // ; :
            8'h52: begin w_lo = 7'h27; w_hi = 7'h22; end     // ' "
            8'h41: begin w_lo = 7'h2C; w_hi = 7'h3C; end     // , <
            8'h49: begin w_lo = 7'h2E; w_hi = 7'h3E; end     // . >
            8'h4A: begin w_lo = 7'h2F; w_hi = 7'h3F; end     // / ?
            8'h0E: begin w_lo = 7'h60; w_hi = 7'h7E; end     // ` ~
            8'h29: begin w_lo = 7'h20; w_hi = 7'h20; end     // space
            8'h5A: begin w_lo = 7'h0D; w_hi = 7'h0D; end     // enter
            8'h66: begin w_lo = 7'h08; w_hi = 7'h08; end     // backspace
            8'h0D: begin w_lo = 7'h09; w_hi = 7'h09; end     // tab
            8'h76: begin w_lo = 7'h1B; w_hi = 7'h1B; end     // esc
            default: ;
        endcase
        // Letters carry only the lowercase form; uppercase differs in bit 5.
        if (w_letter) begin
            w_hi = w_lo ^ 7'h20;
        end
    end

    assign w_hit      = (w_lo != 7'h00);
    assign w_is_shift = ~r_extend & ((r_code == 8'h12) | (r_code == 8'h59));
    assign w_is_ctrl  = (r_code == 8'h14);
    assign w_is_caps  = ~r_extend & (r_code == 8'h58);

    // Only E0 5A survives among extended codes; releases never emit.
    assign w_keep = ~(w_is_shift | w_is_ctrl | w_is_caps) & ~r_keyup &
                    (r_extend ? (r_code == 8'h5A) : w_hit);

    always_comb begin
        w_char = r_shift ? w_hi : w_lo;
        if (w_letter) begin
            w_char = (r_shift ^ r_caps) ? w_hi : w_lo;
            if (CTRL_MAP && r_ctrl) begin
                w_char = w_char & 7'h1F;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state    <= c_ST_IDLE;
            r_keyup    <= 1'b0;
            r_extend   <= 1'b0;
            r_code     <= 8'h00;
            r_shift    <= 1'b0;
            r_ctrl     <= 1'b0;
            r_caps     <= CAPS_INIT;
            r_ascii    <= 7'h00;
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= kb_overflow;
            if (r_valid && ascii_ready) begin
                r_valid <= 1'b0;
            end
            case (r_state)
                c_ST_IDLE: begin
                    if (w_pop) begin
                        r_keyup  <= kb_keyup;
                        r_extend <= kb_extend;
                        r_code   <= kb_scancode;
                        r_state  <= c_ST_LOOKUP;
                    end
                end
                c_ST_LOOKUP: begin
                    if (w_is_shift) r_shift <= ~r_keyup;
                    if (w_is_ctrl)  r_ctrl  <= ~r_keyup;
                    if (w_is_caps && !r_keyup) r_caps <= ~r_caps;
                    // The output register is loaded on entry to EMIT so the
                    // character is already visible during the EMIT cycle.
                    if (w_keep) begin
                        r_ascii <= w_char;
                        r_valid <= 1'b1;
                        r_state <= c_ST_EMIT;
                    end else begin
                        r_state <= c_ST_IDLE;
                    end
                end
                c_ST_EMIT: r_state <= c_ST_IDLE;
                default:   r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign ascii       = {1'b0, r_ascii};
    assign ascii_valid = r_valid;
    assign mods        = {r_caps, r_ctrl, r_shift};
    assign overflow    = r_overflow;

endmodule
`default_nettype wire
